paralelo_serial_link: RTL and testbench

- 10-bit parallel-to-serial transmitter (paraleloSerial half) plus serial-to-parallel receiver (serialParalelo half) in one block, sharing one clock.
- Transmitter shifts one word out per WIDTH clocks, MSB first, on salida.
- Receiver rebuilds words from entrada and presents them on salidas.
- Sits between the parallel datapath and the serial lane; normally salida is wired to entrada, directly or through the lane.

---
 rtl/paralelo_serial_link.sv | 75 +++++++
 tb/tb_paralelo_serial_link.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/paralelo_serial_link.sv
// Parallel-to-serial transmitter and serial-to-parallel receiver sharing one clock.
// Both halves run free-running frame counters that stay in lockstep from reset.
module paralelo_serial_link #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] entradas,
  output logic             salida,
  input  logic             entrada,
  output logic [WIDTH-1:0] salidas
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] txCnt_q, txCnt_d;
  logic [WIDTH-2:0] txShift_q, txShift_d;
  logic             salida_q, salida_d;

  logic [CNT_W-1:0] rxCnt_q, rxCnt_d;
  logic [WIDTH-2:0] rxShift_q, rxShift_d;
  logic [WIDTH-1:0] salidas_q, salidas_d;
  logic             primed_q, primed_d;

  // Transmitter: load the word at frame start, then walk the held bits out MSB first.
  always_comb begin
    txCnt_d = (txCnt_q == LAST) ? '0 : txCnt_q + 1'b1;
    if (txCnt_q == '0) begin
      salida_d  = entradas[WIDTH-1];
      txShift_d = entradas[WIDTH-2:0];
    end else begin
      salida_d  = txShift_q[WIDTH-2];
      txShift_d = {txShift_q[WIDTH-3:0], 1'b0};
    end
  end

  // Receiver: the first frame boundary after reset only arms the output, since no full word exists yet.
  always_comb begin
    rxCnt_d   = (rxCnt_q == LAST) ? '0 : rxCnt_q + 1'b1;
    rxShift_d = {rxShift_q[WIDTH-3:0], entrada};
    salidas_d = salidas_q;
    primed_d  = primed_q;
    if (rxCnt_q == '0) begin
      primed_d = 1'b1;
      if (primed_q) begin
        salidas_d = {rxShift_q, entrada};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      txCnt_q   <= '0;
      txShift_q <= '0;
      salida_q  <= 1'b0;
      rxCnt_q   <= '0;
      rxShift_q <= '0;
      salidas_q <= '0;
      primed_q  <= 1'b0;
    end else begin
      txCnt_q   <= txCnt_d;
      txShift_q <= txShift_d;
      salida_q  <= salida_d;
      rxCnt_q   <= rxCnt_d;
      rxShift_q <= rxShift_d;
      salidas_q <= salidas_d;
      primed_q  <= primed_d;
    end
  end

  assign salida  = salida_q;
  assign salidas = salidas_q;

endmodule

// File: tb/tb_paralelo_serial_link.sv
// Self-checking bench for paralelo_serial_link: fixed vector table, directed corner cases,
// and randomized traffic compared against a frame-position reference model.
module tb_paralelo_serial_link;

  localparam int W = 10;

  logic         clk;
  logic         reset_L;
  logic [W-1:0] entradas;
  logic         salida;
  logic         entrada;
  logic [W-1:0] salidas;
  logic         useLoop;
  logic         entradaDrv;

  int checks;
  int errors;

  // Reference model: edge index since reset, word held for the frame, received bit history.
  int           mT;
  logic [W-1:0] mHeld;
  logic         mSalida;
  logic [W-1:0] mSalidas;
  logic         mHist[$];

  typedef struct {
    logic         rstL;
    logic [W-1:0] word;
    logic         expSalida;
    logic [W-1:0] expSalidas;
  } vec_t;

  vec_t vecs[13];

  localparam logic [W-1:0] WA = 10'b1010010101;
  localparam logic [W-1:0] WB1 = 10'b1111100000;
  localparam logic [W-1:0] WB2 = 10'b0000011111;
  localparam logic [W-1:0] WX = 10'bx10x10x10x;

  assign entrada = useLoop ? salida : entradaDrv;

  paralelo_serial_link #(.WIDTH(W), .CNT_W(4)) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .entradas (entradas),
    .salida   (salida),
    .entrada  (entrada),
    .salidas  (salidas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b (model edge %0d)", name, act, exp, mT);
    end
  endtask

  // One clock edge: drive inputs, advance the model by the rules of the frame, compare outputs.
  task automatic applyStimulus(input logic rstL, input logic [W-1:0] word, input logic entDrv);
    logic entVal;
    int   k;
    @(negedge clk);
    reset_L    = rstL;
    entradas   = word;
    entradaDrv = entDrv;
    #1;
    entVal = entrada;
    @(posedge clk);
    #1;
    if (!rstL) begin
      mT       = 0;
      mHeld    = '0;
      mSalida  = 1'b0;
      mSalidas = '0;
      mHist.delete();
    end else begin
      k = mT % W;
      if (k == 0) mHeld = word;
      mSalida = mHeld[W-1-k];
      mHist.push_back(entVal);
      if (mHist.size() > W) void'(mHist.pop_front());
      if (k == 0 && mT >= W) begin
        for (int i = 0; i < W; i++) mSalidas[i] = mHist[mHist.size()-1-i];
      end
      mT++;
    end
    checkOutput("salida", {{(W-1){1'b0}}, salida}, {{(W-1){1'b0}}, mSalida});
    checkOutput("salidas", salidas, mSalidas);
  endtask

  task automatic runEdges(input int n, input logic [W-1:0] word);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, word, 1'b0);
  endtask

  initial begin
    logic [W-1:0] rw;
    checks     = 0;
    errors     = 0;
    useLoop    = 1'b1;
    entradaDrv = 1'b0;
    reset_L    = 1'b0;
    entradas   = '0;
    mT         = 0;
    mHeld      = '0;
    mSalida    = 1'b0;
    mSalidas   = '0;

    vecs[0]  = '{1'b0, 10'b1111111111, 1'b0, 10'b0};
    vecs[1]  = '{1'b0, 10'b1111111111, 1'b0, 10'b0};
    vecs[2]  = '{1'b1, WA, 1'b1, 10'b0};
    vecs[3]  = '{1'b1, WA, 1'b0, 10'b0};
    vecs[4]  = '{1'b1, WA, 1'b1, 10'b0};
    vecs[5]  = '{1'b1, WA, 1'b0, 10'b0};
    vecs[6]  = '{1'b1, WA, 1'b0, 10'b0};
    vecs[7]  = '{1'b1, WA, 1'b1, 10'b0};
    vecs[8]  = '{1'b1, WA, 1'b0, 10'b0};
    vecs[9]  = '{1'b1, WA, 1'b1, 10'b0};
    vecs[10] = '{1'b1, WA, 1'b0, 10'b0};
    vecs[11] = '{1'b1, WA, 1'b1, 10'b0};
    vecs[12] = '{1'b1, WA, 1'b1, WA};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rstL, vecs[i].word, 1'b0);
      checkOutput($sformatf("vec%0d salida", i), {{(W-1){1'b0}}, salida}, {{(W-1){1'b0}}, vecs[i].expSalida});
      checkOutput($sformatf("vec%0d salidas", i), salidas, vecs[i].expSalidas);
    end

    // Back-to-back words, each applied one edge before its frame start.
    runEdges(8, WA);
    runEdges(10, WB1);
    runEdges(2, WB2);
    checkOutput("b2b word1", salidas, WB1);
    runEdges(10, WB2);
    checkOutput("b2b word2", salidas, WB2);

    // Mid-frame change at counter 4 must not disturb the frame in flight.
    runEdges(9, WA);
    runEdges(4, WA);
    runEdges(6, WB2);
    runEdges(1, WB2);
    checkOutput("midframe old word", salidas, WA);
    runEdges(10, WB2);
    checkOutput("midframe new word", salidas, WB2);

    // Reset at counter 6 discards the partial word.
    runEdges(5, WA);
    applyStimulus(1'b0, WA, 1'b0);
    checkOutput("midreset salidas", salidas, 10'b0);
    runEdges(10, WB2);
    checkOutput("restart no partial", salidas, 10'b0);
    runEdges(1, WB2);
    checkOutput("restart first word", salidas, WB2);

    // Unknown bits travel through both halves untouched.
    runEdges(9, WB2);
    runEdges(10, WX);
    runEdges(1, WX);
    checkOutput("x word", salidas, WX);

    // Randomized traffic with occasional resets and direct receiver drive.
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) useLoop = ($urandom_range(0, 1) == 1);
      rw = W'($urandom);
      applyStimulus(($urandom_range(0, 59) != 0), rw, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
